// File: rtl/id_stage_hzd.sv
// LoongArch32 decode stage: GPR file, multi-source operand forwarding, load-use stall, branch resolve/squash.
// Optional ID_PERF_CNT_EN adds stall/squash event counters.
module id_fwd_sel #(
   parameter int NFWD = 3
) (
   input  logic [4:0]             addr,
   input  logic [31:0]            rf_q,
   input  logic                   rf_we,
   input  logic [4:0]             rf_waddr,
   input  logic [31:0]            rf_wdata,
   input  logic [NFWD-1:0]        fwd_vld,
   input  logic [NFWD-1:0][4:0]   fwd_dest,
   input  logic [NFWD-1:0][31:0]  fwd_data,
   input  logic [NFWD-1:0]        fwd_rdy,
   output logic [31:0]            val,
   output logic                   busy
);
   // Scan oldest to youngest so the youngest matching stage overrides.
   always_comb begin
      val  = (rf_we && rf_waddr == addr) ? rf_wdata : rf_q;
      busy = 1'b0;
      for (int i = NFWD-1; i >= 0; i--) begin
         if (fwd_vld[i] && fwd_dest[i] == addr) begin
            val  = fwd_data[i];
            busy = !fwd_rdy[i];
         end
      end
      if (addr == 5'd0) begin
         val  = 32'h0;
         busy = 1'b0;
      end
   end
endmodule

module id_stage_hzd #(
   parameter int          NFWD        = 3,
   parameter logic [31:0] RESET_PC_DS = 32'h0
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   fs_to_ds_valid,
   input  logic [31:0]            fs_inst,
   input  logic [31:0]            fs_pc,
   output logic                   ds_allowin,
   input  logic                   es_allowin,
   output logic                   ds_to_es_valid,
   output logic [11:0]            es_alu_op,
   output logic                   es_src1_is_pc,
   output logic                   es_src2_is_imm,
   output logic                   es_res_from_mem,
   output logic                   es_gr_we,
   output logic                   es_mem_we,
   output logic [4:0]             es_dest,
   output logic [31:0]            es_imm,
   output logic [31:0]            es_rj_value,
   output logic [31:0]            es_rkd_value,
   output logic [31:0]            es_pc,
   output logic                   br_taken,
   output logic [31:0]            br_target,
   input  logic [NFWD-1:0]        fwd_vld,
   input  logic [NFWD-1:0][4:0]   fwd_dest,
   input  logic [NFWD-1:0][31:0]  fwd_data,
   input  logic [NFWD-1:0]        fwd_rdy,
   input  logic                   rf_we,
   input  logic [4:0]             rf_waddr,
   input  logic [31:0]            rf_wdata
`ifdef ID_PERF_CNT_EN
  ,output logic [31:0]            ds_stall_cnt,
   output logic [31:0]            ds_squash_cnt
`endif
);
   logic        ds_valid, ds_ready_go;
   logic [31:0] ds_inst, ds_pc;
   logic [31:0] gpr [32];

   always_ff @(posedge clk) begin
      if (reset) begin
         ds_valid <= 1'b0;
         ds_inst  <= 32'h0;
         ds_pc    <= RESET_PC_DS;
      end else begin
         if (ds_allowin) ds_valid <= fs_to_ds_valid && !br_taken;
         if (fs_to_ds_valid && ds_allowin) begin
            ds_inst <= fs_inst;
            ds_pc   <= fs_pc;
         end
      end
   end

   always_ff @(posedge clk)
      if (rf_we && rf_waddr != 5'd0) gpr[rf_waddr] <= rf_wdata;

   logic [4:0]  rd, rj, rk;
   logic [11:0] i12;
   logic [15:0] i16;
   logic [19:0] i20;
   logic [25:0] i26;
   logic [5:0]  op6;
   logic [3:0]  op4;
   logic [1:0]  op2;
   logic [4:0]  op5;
   assign rd  = ds_inst[4:0];
   assign rj  = ds_inst[9:5];
   assign rk  = ds_inst[14:10];
   assign i12 = ds_inst[21:10];
   assign i16 = ds_inst[25:10];
   assign i20 = ds_inst[24:5];
   assign i26 = {ds_inst[9:0], ds_inst[25:10]};
   assign op6 = ds_inst[31:26];
   assign op4 = ds_inst[25:22];
   assign op2 = ds_inst[21:20];
   assign op5 = ds_inst[19:15];

   logic is_3r, is_sh, is_ri;
   assign is_3r = op6 == 6'h00 && op4 == 4'h0 && op2 == 2'h1;
   assign is_sh = op6 == 6'h00 && op4 == 4'h1 && op2 == 2'h0;
   assign is_ri = op6 == 6'h00;

   logic i_add, i_sub, i_slt, i_sltu, i_nor, i_and, i_or, i_xor;
   logic i_slli, i_srli, i_srai, i_addi, i_slti, i_sltui, i_andi, i_ori, i_xori;
   logic i_ld, i_st, i_lu12i, i_pcadd, i_jirl, i_b, i_bl;
   logic i_beq, i_bne, i_blt, i_bge, i_bltu, i_bgeu;
   assign i_add   = is_3r && op5 == 5'h00;
   assign i_sub   = is_3r && op5 == 5'h02;
   assign i_slt   = is_3r && op5 == 5'h04;
   assign i_sltu  = is_3r && op5 == 5'h05;
   assign i_nor   = is_3r && op5 == 5'h08;
   assign i_and   = is_3r && op5 == 5'h09;
   assign i_or    = is_3r && op5 == 5'h0a;
   assign i_xor   = is_3r && op5 == 5'h0b;
   assign i_slli  = is_sh && op5 == 5'h01;
   assign i_srli  = is_sh && op5 == 5'h09;
   assign i_srai  = is_sh && op5 == 5'h11;
   assign i_slti  = is_ri && op4 == 4'h8;
   assign i_sltui = is_ri && op4 == 4'h9;
   assign i_addi  = is_ri && op4 == 4'ha;
   assign i_andi  = is_ri && op4 == 4'hd;
   assign i_ori   = is_ri && op4 == 4'he;
   assign i_xori  = is_ri && op4 == 4'hf;
   assign i_ld    = op6 == 6'h0a && op4 == 4'h2;
   assign i_st    = op6 == 6'h0a && op4 == 4'h6;
   assign i_lu12i = ds_inst[31:25] == 7'h0a;
   assign i_pcadd = ds_inst[31:25] == 7'h0e;
   assign i_jirl  = op6 == 6'h13;
   assign i_b     = op6 == 6'h14;
   assign i_bl    = op6 == 6'h15;
   assign i_beq   = op6 == 6'h16;
   assign i_bne   = op6 == 6'h17;
   assign i_blt   = op6 == 6'h18;
   assign i_bge   = op6 == 6'h19;
   assign i_bltu  = op6 == 6'h1a;
   assign i_bgeu  = op6 == 6'h1b;

   logic op_3r, op_sh, op_ri, op_cbr, gr_we, use_rj, use_rkd;
   assign op_3r   = i_add | i_sub | i_slt | i_sltu | i_nor | i_and | i_or | i_xor;
   assign op_sh   = i_slli | i_srli | i_srai;
   assign op_ri   = i_addi | i_slti | i_sltui | i_andi | i_ori | i_xori;
   assign op_cbr  = i_beq | i_bne | i_blt | i_bge | i_bltu | i_bgeu;
   assign gr_we   = op_3r | op_sh | op_ri | i_ld | i_lu12i | i_pcadd | i_jirl | i_bl;
   assign use_rj  = op_3r | op_sh | op_ri | i_ld | i_st | i_jirl | op_cbr;
   assign use_rkd = op_3r | i_st | op_cbr;

   assign es_alu_op = {i_lu12i, i_srai, i_srli, i_slli, i_xor | i_xori, i_or | i_ori, i_nor,
                       i_and | i_andi, i_sltu | i_sltui, i_slt | i_slti, i_sub,
                       i_add | i_addi | i_ld | i_st | i_pcadd | i_jirl | i_bl};
   assign es_src1_is_pc  = i_jirl | i_bl | i_pcadd;
   assign es_src2_is_imm = op_sh | op_ri | i_ld | i_st | i_lu12i | i_pcadd | i_jirl | i_bl;

   always_comb begin
      es_imm = 32'h0;
      if (op_sh)                                   es_imm = {27'b0, rk};
      else if (i_andi | i_ori | i_xori)            es_imm = {20'b0, i12};
      else if (i_addi | i_slti | i_sltui | i_ld | i_st)
                                                   es_imm = {{20{i12[11]}}, i12};
      else if (i_lu12i | i_pcadd)                  es_imm = {i20, 12'b0};
      else if (i_jirl | i_bl)                      es_imm = 32'd4;
   end

   // Stores and conditional branches carry their second operand in rd.
   logic [4:0]  rkd;
   logic [31:0] rf_rj, rf_rkd;
   logic        rj_busy, rkd_busy;
   assign rkd    = (i_st | op_cbr) ? rd : rk;
   assign rf_rj  = gpr[rj];
   assign rf_rkd = gpr[rkd];

   id_fwd_sel #(.NFWD(NFWD)) u_fwd_rj (
      .addr(rj), .rf_q(rf_rj), .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
      .fwd_vld(fwd_vld), .fwd_dest(fwd_dest), .fwd_data(fwd_data), .fwd_rdy(fwd_rdy),
      .val(es_rj_value), .busy(rj_busy));
   id_fwd_sel #(.NFWD(NFWD)) u_fwd_rkd (
      .addr(rkd), .rf_q(rf_rkd), .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
      .fwd_vld(fwd_vld), .fwd_dest(fwd_dest), .fwd_data(fwd_data), .fwd_rdy(fwd_rdy),
      .val(es_rkd_value), .busy(rkd_busy));

   assign ds_ready_go    = !((use_rj && rj_busy) || (use_rkd && rkd_busy));
   assign ds_allowin     = !ds_valid || (ds_ready_go && es_allowin);
   assign ds_to_es_valid = ds_valid && ds_ready_go;

   assign es_gr_we        = ds_valid && gr_we;
   assign es_mem_we       = ds_valid && i_st;
   assign es_res_from_mem = ds_valid && i_ld;
   assign es_dest         = i_bl ? 5'd1 : rd;
   assign es_pc           = ds_pc;

   logic        cond;
   logic [31:0] off16, off26;
   assign off16 = {{14{i16[15]}}, i16, 2'b0};
   assign off26 = {{4{i26[25]}}, i26, 2'b0};
   assign cond = i_jirl | i_b | i_bl
               | (i_beq  && es_rj_value == es_rkd_value)
               | (i_bne  && es_rj_value != es_rkd_value)
               | (i_blt  && $signed(es_rj_value) <  $signed(es_rkd_value))
               | (i_bge  && $signed(es_rj_value) >= $signed(es_rkd_value))
               | (i_bltu && es_rj_value <  es_rkd_value)
               | (i_bgeu && es_rj_value >= es_rkd_value);
   assign br_taken  = ds_valid && ds_ready_go && es_allowin && cond;
   assign br_target = i_jirl ? es_rj_value + off16 : ds_pc + ((i_b | i_bl) ? off26 : off16);

`ifdef ID_PERF_CNT_EN
   always_ff @(posedge clk) begin
      if (reset) begin
         ds_stall_cnt  <= 32'h0;
         ds_squash_cnt <= 32'h0;
      end else begin
         if (ds_valid && !ds_ready_go) ds_stall_cnt <= ds_stall_cnt + 32'd1;
         if (fs_to_ds_valid && ds_allowin && br_taken) ds_squash_cnt <= ds_squash_cnt + 32'd1;
      end
   end
`endif
endmodule

// File: tb/tb_id_stage_hzd.sv
// Randomised bench for id_stage_hzd with a mnemonic-level reference model plus directed scenarios.
module tb_id_stage_hzd;
   localparam int NFWD = 3;

   typedef enum int {
      M_ADD, M_SUB, M_SLT, M_SLTU, M_NOR, M_AND, M_OR, M_XOR,
      M_SLLI, M_SRLI, M_SRAI,
      M_ADDI, M_SLTI, M_SLTUI, M_ANDI, M_ORI, M_XORI,
      M_LD, M_ST, M_LU12I, M_PCADDU12I,
      M_JIRL, M_B, M_BL, M_BEQ, M_BNE, M_BLT, M_BGE, M_BLTU, M_BGEU,
      M_NOP
   } mn_t;

   typedef struct packed {
      logic [11:0] alu;
      logic        s1pc, s2imm, ld, we, st, urj, urkd, rkd_rd;
      logic [4:0]  dest;
      logic [31:0] imm;
   } dec_t;

   logic                  clk = 1'b0;
   logic                  reset;
   logic                  fs_to_ds_valid;
   logic [31:0]           fs_inst, fs_pc;
   logic                  ds_allowin, es_allowin, ds_to_es_valid;
   logic [11:0]           es_alu_op;
   logic                  es_src1_is_pc, es_src2_is_imm, es_res_from_mem, es_gr_we, es_mem_we;
   logic [4:0]            es_dest;
   logic [31:0]           es_imm, es_rj_value, es_rkd_value, es_pc;
   logic                  br_taken;
   logic [31:0]           br_target;
   logic [NFWD-1:0]       fwd_vld, fwd_rdy;
   logic [NFWD-1:0][4:0]  fwd_dest;
   logic [NFWD-1:0][31:0] fwd_data;
   logic                  rf_we;
   logic [4:0]            rf_waddr;
   logic [31:0]           rf_wdata;
`ifdef ID_PERF_CNT_EN
   logic [31:0]           ds_stall_cnt, ds_squash_cnt;
`endif

   id_stage_hzd #(.NFWD(NFWD), .RESET_PC_DS(32'h0)) dut (
      .clk(clk), .reset(reset),
      .fs_to_ds_valid(fs_to_ds_valid), .fs_inst(fs_inst), .fs_pc(fs_pc),
      .ds_allowin(ds_allowin), .es_allowin(es_allowin), .ds_to_es_valid(ds_to_es_valid),
      .es_alu_op(es_alu_op), .es_src1_is_pc(es_src1_is_pc), .es_src2_is_imm(es_src2_is_imm),
      .es_res_from_mem(es_res_from_mem), .es_gr_we(es_gr_we), .es_mem_we(es_mem_we),
      .es_dest(es_dest), .es_imm(es_imm), .es_rj_value(es_rj_value), .es_rkd_value(es_rkd_value),
      .es_pc(es_pc), .br_taken(br_taken), .br_target(br_target),
      .fwd_vld(fwd_vld), .fwd_dest(fwd_dest), .fwd_data(fwd_data), .fwd_rdy(fwd_rdy),
      .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata)
`ifdef ID_PERF_CNT_EN
     ,.ds_stall_cnt(ds_stall_cnt), .ds_squash_cnt(ds_squash_cnt)
`endif
   );

   always #5 clk = ~clk;

   int   n_chk = 0, n_err = 0;
   logic chk_on = 1'b0;
   mn_t  fs_mn = M_NOP;

   task automatic ck(input string nm, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h at %0t", nm, got, exp, $time);
      end
   endtask

   function automatic logic [31:0] enc(mn_t m, logic [4:0] rd, logic [4:0] rj, logic [4:0] rk, logic [25:0] im);
      case (m)
         M_ADD:  return {17'h00020, rk, rj, rd};
         M_SUB:  return {17'h00022, rk, rj, rd};
         M_SLT:  return {17'h00024, rk, rj, rd};
         M_SLTU: return {17'h00025, rk, rj, rd};
         M_NOR:  return {17'h00028, rk, rj, rd};
         M_AND:  return {17'h00029, rk, rj, rd};
         M_OR:   return {17'h0002a, rk, rj, rd};
         M_XOR:  return {17'h0002b, rk, rj, rd};
         M_SLLI: return {17'h00081, im[4:0], rj, rd};
         M_SRLI: return {17'h00089, im[4:0], rj, rd};
         M_SRAI: return {17'h00091, im[4:0], rj, rd};
         M_SLTI: return {10'h008, im[11:0], rj, rd};
         M_SLTUI:return {10'h009, im[11:0], rj, rd};
         M_ADDI: return {10'h00a, im[11:0], rj, rd};
         M_ANDI: return {10'h00d, im[11:0], rj, rd};
         M_ORI:  return {10'h00e, im[11:0], rj, rd};
         M_XORI: return {10'h00f, im[11:0], rj, rd};
         M_LD:   return {10'h0a2, im[11:0], rj, rd};
         M_ST:   return {10'h0a6, im[11:0], rj, rd};
         M_LU12I:     return {7'h0a, im[19:0], rd};
         M_PCADDU12I: return {7'h0e, im[19:0], rd};
         M_JIRL: return {6'h13, im[15:0], rj, rd};
         M_B:    return {6'h14, im[15:0], im[25:16]};
         M_BL:   return {6'h15, im[15:0], im[25:16]};
         M_BEQ:  return {6'h16, im[15:0], rj, rd};
         M_BNE:  return {6'h17, im[15:0], rj, rd};
         M_BLT:  return {6'h18, im[15:0], rj, rd};
         M_BGE:  return {6'h19, im[15:0], rj, rd};
         M_BLTU: return {6'h1a, im[15:0], rj, rd};
         M_BGEU: return {6'h1b, im[15:0], rj, rd};
         default: return {6'h3f, im};
      endcase
   endfunction

   // What execute must see for a given mnemonic, taken straight from the ISA semantics.
   function automatic dec_t mdec(mn_t m, logic [31:0] in);
      dec_t d;
      d = '0;
      d.dest = in[4:0];
      case (m)
         M_ADD, M_SUB, M_SLT, M_SLTU, M_NOR, M_AND, M_OR, M_XOR: begin
            d.we = 1; d.urj = 1; d.urkd = 1;
            case (m)
               M_ADD: d.alu[0] = 1; M_SUB: d.alu[1] = 1; M_SLT: d.alu[2] = 1;
               M_SLTU: d.alu[3] = 1; M_AND: d.alu[4] = 1; M_NOR: d.alu[5] = 1;
               M_OR: d.alu[6] = 1; default: d.alu[7] = 1;
            endcase
         end
         M_SLLI, M_SRLI, M_SRAI: begin
            d.we = 1; d.urj = 1; d.s2imm = 1; d.imm = {27'b0, in[14:10]};
            case (m) M_SLLI: d.alu[8] = 1; M_SRLI: d.alu[9] = 1; default: d.alu[10] = 1; endcase
         end
         M_ADDI, M_SLTI, M_SLTUI, M_LD, M_ST: begin
            d.urj = 1; d.s2imm = 1; d.imm = {{20{in[21]}}, in[21:10]};
            case (m)
               M_SLTI: begin d.alu[2] = 1; d.we = 1; end
               M_SLTUI: begin d.alu[3] = 1; d.we = 1; end
               M_LD: begin d.alu[0] = 1; d.we = 1; d.ld = 1; end
               M_ST: begin d.alu[0] = 1; d.st = 1; d.urkd = 1; d.rkd_rd = 1; end
               default: begin d.alu[0] = 1; d.we = 1; end
            endcase
         end
         M_ANDI, M_ORI, M_XORI: begin
            d.we = 1; d.urj = 1; d.s2imm = 1; d.imm = {20'b0, in[21:10]};
            case (m) M_ANDI: d.alu[4] = 1; M_ORI: d.alu[6] = 1; default: d.alu[7] = 1; endcase
         end
         M_LU12I:     begin d.alu[11] = 1; d.we = 1; d.s2imm = 1; d.imm = {in[24:5], 12'b0}; end
         M_PCADDU12I: begin d.alu[0] = 1; d.we = 1; d.s1pc = 1; d.s2imm = 1; d.imm = {in[24:5], 12'b0}; end
         M_JIRL: begin d.alu[0] = 1; d.we = 1; d.s1pc = 1; d.s2imm = 1; d.imm = 32'd4; d.urj = 1; end
         M_BL:   begin d.alu[0] = 1; d.we = 1; d.s1pc = 1; d.s2imm = 1; d.imm = 32'd4; d.dest = 5'd1; end
         M_BEQ, M_BNE, M_BLT, M_BGE, M_BLTU, M_BGEU: begin d.urj = 1; d.urkd = 1; d.rkd_rd = 1; end
         default: ;
      endcase
      return d;
   endfunction

   logic [31:0] gpr [32];
   initial for (int i = 0; i < 32; i++) gpr[i] = 32'h0;

   // {stall, value}: first (youngest) matching stage wins, else regfile with write-through.
   function automatic logic [32:0] opnd(input logic [4:0] a);
      if (a == 5'd0) return 33'h0;
      for (int i = 0; i < NFWD; i++)
         if (fwd_vld[i] && fwd_dest[i] == a) return {!fwd_rdy[i], fwd_data[i]};
      if (rf_we && rf_waddr == a) return {1'b0, rf_wdata};
      return {1'b0, gpr[a]};
   endfunction

   logic        m_valid = 0, n_valid = 0;
   logic [31:0] m_inst = 0, m_pc = 0, n_inst = 0, n_pc = 0;
   mn_t         m_mn = M_NOP, n_mn = M_NOP;
   logic [31:0] m_stall = 0, m_squash = 0, n_stall = 0, n_squash = 0;

   always @(negedge clk) begin : chk
      dec_t        d;
      logic [32:0] a, b;
      logic        rdy, allow, tov, cond, brt;
      logic [31:0] tgt, o16, o26;
      d   = mdec(m_mn, m_inst);
      a   = opnd(m_inst[9:5]);
      b   = opnd(d.rkd_rd ? m_inst[4:0] : m_inst[14:10]);
      rdy = !((d.urj && a[32]) || (d.urkd && b[32]));
      allow = !m_valid || (rdy && es_allowin);
      tov = m_valid && rdy;
      o16 = {{14{m_inst[25]}}, m_inst[25:10], 2'b0};
      o26 = {{4{m_inst[9]}}, m_inst[9:0], m_inst[25:10], 2'b0};
      case (m_mn)
         M_JIRL, M_B, M_BL: cond = 1;
         M_BEQ:  cond = a[31:0] == b[31:0];
         M_BNE:  cond = a[31:0] != b[31:0];
         M_BLT:  cond = $signed(a[31:0]) <  $signed(b[31:0]);
         M_BGE:  cond = $signed(a[31:0]) >= $signed(b[31:0]);
         M_BLTU: cond = a[31:0] <  b[31:0];
         M_BGEU: cond = a[31:0] >= b[31:0];
         default: cond = 0;
      endcase
      tgt = (m_mn == M_JIRL) ? a[31:0] + o16 : m_pc + ((m_mn == M_B || m_mn == M_BL) ? o26 : o16);
      brt = tov && es_allowin && cond;
      if (chk_on) begin
         ck("ds_allowin", 32'(ds_allowin), 32'(allow));
         ck("ds_to_es_valid", 32'(ds_to_es_valid), 32'(tov));
         ck("br_taken", 32'(br_taken), 32'(brt));
         ck("es_gr_we", 32'(es_gr_we), 32'(m_valid && d.we));
         ck("es_mem_we", 32'(es_mem_we), 32'(m_valid && d.st));
         ck("es_res_from_mem", 32'(es_res_from_mem), 32'(m_valid && d.ld));
         if (brt) ck("br_target", br_target, tgt);
         if (tov) begin
            ck("es_alu_op", 32'(es_alu_op), 32'(d.alu));
            ck("es_src1_is_pc", 32'(es_src1_is_pc), 32'(d.s1pc));
            ck("es_src2_is_imm", 32'(es_src2_is_imm), 32'(d.s2imm));
            ck("es_imm", es_imm, d.imm);
            ck("es_pc", es_pc, m_pc);
            if (d.we)   ck("es_dest", 32'(es_dest), 32'(d.dest));
            if (d.urj)  ck("es_rj_value", es_rj_value, a[31:0]);
            if (d.urkd) ck("es_rkd_value", es_rkd_value, b[31:0]);
         end
`ifdef ID_PERF_CNT_EN
         ck("ds_stall_cnt", ds_stall_cnt, m_stall);
         ck("ds_squash_cnt", ds_squash_cnt, m_squash);
`endif
      end
      n_valid = m_valid; n_inst = m_inst; n_pc = m_pc; n_mn = m_mn;
      n_stall = m_stall + 32'(m_valid && !rdy);
      n_squash = m_squash + 32'(fs_to_ds_valid && allow && brt);
      if (reset) begin
         n_valid = 0; n_inst = 0; n_pc = 0; n_mn = M_NOP; n_stall = 0; n_squash = 0;
      end else if (allow) begin
         n_valid = fs_to_ds_valid && !brt;
         if (fs_to_ds_valid) begin n_inst = fs_inst; n_pc = fs_pc; n_mn = fs_mn; end
      end
   end

   always @(posedge clk) begin
      m_valid = n_valid; m_inst = n_inst; m_pc = n_pc; m_mn = n_mn;
      m_stall = n_stall; m_squash = n_squash;
      if (rf_we && rf_waddr != 5'd0) gpr[rf_waddr] = rf_wdata;
   end

   task automatic cyc();
      @(posedge clk); #1;
      fs_to_ds_valid = 0; es_allowin = 1; fwd_vld = '0; fwd_rdy = '1;
      fwd_dest = '0; fwd_data = '0; rf_we = 0; rf_waddr = 0; rf_wdata = 0;
   endtask

   task automatic fetch(input mn_t m, input logic [31:0] in, input logic [31:0] pc);
      fs_to_ds_valid = 1; fs_inst = in; fs_pc = pc; fs_mn = m;
   endtask

   initial begin
      reset = 1; fs_to_ds_valid = 0; fs_inst = 0; fs_pc = 0; es_allowin = 1;
      fwd_vld = '0; fwd_rdy = '1; fwd_dest = '0; fwd_data = '0;
      rf_we = 0; rf_waddr = 0; rf_wdata = 0;
      @(posedge clk); @(posedge clk); #1;
      chk_on = 1;
      cyc(); reset = 0;
      @(negedge clk);
      ck("rst ds_allowin", 32'(ds_allowin), 32'd1);
      ck("rst ds_to_es_valid", 32'(ds_to_es_valid), 32'd0);
      ck("rst br_taken", 32'(br_taken), 32'd0);

      for (int r = 1; r < 32; r++) begin
         cyc(); rf_we = 1; rf_waddr = 5'(r);
         rf_wdata = (r == 1) ? 32'hFFFF_FFFF : (r == 2) ? 32'h7FFF_FFFF : (r == 5) ? 32'h11 : $urandom;
      end

      // Youngest forwarding source beats an older one and the regfile.
      cyc(); fetch(M_ADD, enc(M_ADD, 5'd6, 5'd5, 5'd5, 26'd0), 32'h1C00_0100);
      cyc(); fwd_vld = 3'b101; fwd_dest[0] = 5'd5; fwd_data[0] = 32'h22;
      fwd_dest[2] = 5'd5; fwd_data[2] = 32'h33; fwd_rdy[2] = 1'b0;
      fetch(M_ADDI, enc(M_ADDI, 5'd7, 5'd4, 5'd0, 26'd1), 32'h1C00_0104);
      @(negedge clk);
      ck("fwd rj", es_rj_value, 32'h22);
      ck("fwd rkd", es_rkd_value, 32'h22);
      ck("fwd no stall", 32'(ds_to_es_valid), 32'd1);

      // Load-use: stall one cycle, then take the returned load data.
      cyc(); fwd_vld[0] = 1; fwd_dest[0] = 5'd4; fwd_rdy[0] = 0;
      @(negedge clk);
      ck("lu stall valid", 32'(ds_to_es_valid), 32'd0);
      ck("lu stall allowin", 32'(ds_allowin), 32'd0);
      cyc(); fwd_vld[1] = 1; fwd_dest[1] = 5'd4; fwd_data[1] = 32'h100;
      fetch(M_BGE, enc(M_BGE, 5'd2, 5'd1, 5'd0, 26'd8), 32'h1C00_0020);
      @(negedge clk);
      ck("lu rj", es_rj_value, 32'h100);
      ck("lu valid", 32'(ds_to_es_valid), 32'd1);

      cyc(); fetch(M_BLT, enc(M_BLT, 5'd2, 5'd1, 5'd0, 26'd4), 32'h1C00_0000);
      @(negedge clk);
      ck("bge not taken", 32'(br_taken), 32'd0);
      cyc(); fetch(M_ORI, enc(M_ORI, 5'd9, 5'd3, 5'd0, 26'h1), 32'h1C00_0004);
      @(negedge clk);
      ck("blt taken", 32'(br_taken), 32'd1);
      ck("blt target", br_target, 32'h1C00_0010);
      cyc(); fetch(M_ORI, enc(M_ORI, 5'd8, 5'd3, 5'd0, 26'hF00), 32'h1C00_0010);
      @(negedge clk);
      ck("squash valid", 32'(ds_to_es_valid), 32'd0);
      ck("squash pulse", 32'(br_taken), 32'd0);

      // Write-back in the decode cycle is seen immediately.
      cyc(); rf_we = 1; rf_waddr = 5'd3; rf_wdata = 32'hDEAD;
      fetch(M_ADD, enc(M_ADD, 5'd9, 5'd0, 5'd0, 26'd0), 32'h1C00_0014);
      @(negedge clk);
      ck("wt rj", es_rj_value, 32'hDEAD);
      ck("wt imm", es_imm, 32'h0000_0F00);

      cyc(); fwd_vld[0] = 1; fwd_dest[0] = 5'd0; fwd_rdy[0] = 0;
      fetch(M_ADDI, enc(M_ADDI, 5'd7, 5'd4, 5'd0, 26'd1), 32'h1C00_0018);
      @(negedge clk);
      ck("r0 no stall", 32'(ds_to_es_valid), 32'd1);

      cyc(); fwd_vld[0] = 1; fwd_dest[0] = 5'd4; fwd_rdy[0] = 0; reset = 1;
      @(negedge clk);
      ck("pre-rst stall", 32'(ds_to_es_valid), 32'd0);
      cyc(); reset = 0;
      @(negedge clk);
      ck("post-rst valid", 32'(ds_to_es_valid), 32'd0);
      ck("post-rst br", 32'(br_taken), 32'd0);
`ifdef ID_PERF_CNT_EN
      ck("post-rst stall_cnt", ds_stall_cnt, 32'd0);
      ck("post-rst squash_cnt", ds_squash_cnt, 32'd0);
`endif

      for (int c = 0; c < 4000; c++) begin
         mn_t m;
         cyc();
         reset = ($urandom_range(0, 199) == 0);
         es_allowin = ($urandom_range(0, 4) != 0);
         for (int i = 0; i < NFWD; i++) begin
            fwd_vld[i] = $urandom_range(0, 1);
            fwd_dest[i] = 5'($urandom_range(0, 7));
            fwd_data[i] = $urandom;
            fwd_rdy[i] = ($urandom_range(0, 6) != 0);
         end
         rf_we = $urandom_range(0, 1); rf_waddr = 5'($urandom_range(0, 7)); rf_wdata = $urandom;
         if ($urandom_range(0, 9) < 7) begin
            m = mn_t'($urandom_range(0, 30));
            fetch(m, enc(m, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                         5'($urandom_range(0, 7)), 26'($urandom)), {$urandom_range(0, 32'h3FFF_FFFF), 2'b00});
         end
      end
      cyc(); reset = 0;
      @(negedge clk);
      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end
endmodule
